// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EXE-stage divide sequencer: state encoding
// and the divider result width.
package div_ctrl_pkg;

  localparam int DIV_RES_WD = 64;

  typedef logic [1:0] divc_state_t;

  localparam divc_state_t DIVC_IDLE = 2'd0;
  localparam divc_state_t DIVC_SEND = 2'd1;
  localparam divc_state_t DIVC_WAIT = 2'd2;
  localparam divc_state_t DIVC_DONE = 2'd3;

endpackage

// File: rtl/axis_opnd_chan.sv
// One AXI-Stream operand channel: raises tvalid while enabled and not yet
// accepted, and remembers the completed handshake until cleared.
module axis_opnd_chan (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  input  logic tready_i,
  output logic tvalid_o,
  output logic done_o
);

  logic sent_q, sent_d;
  logic accept;

  assign tvalid_o = en_i & ~sent_q;
  assign accept   = tvalid_o & tready_i;
  // Counts a handshake completing this cycle so both channels can finish together.
  assign done_o   = sent_q | accept;

  always_comb begin
    sent_d = sent_q;
    if (clr_i)       sent_d = 1'b0;
    else if (accept) sent_d = 1'b1;
  end

  // NOTE: flops use non-blocking assignment so every register samples
  // pre-edge values; reset is synchronous like the rest of the pipeline.
  always_ff @(posedge clk) begin
    if (reset) sent_q <= 1'b0;
    else       sent_q <= sent_d;
  end

endmodule

// File: rtl/div_ctrl.sv
// EXE-stage divide sequencer: latches operands, feeds the signed or unsigned
// divider IP, writes HI/LO and drains the IP result of flushed operations.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_RES_WD / 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                es_valid,
  input  logic                op_div,
  input  logic                op_divu,
  input  logic                flush,
  input  logic                ms_allowin,
  input  logic [DATA_W-1:0]   src_a,
  input  logic [DATA_W-1:0]   src_b,
  output logic                s_dividend_tvalid,
  output logic                s_divisor_tvalid,
  input  logic                s_dividend_tready,
  input  logic                s_divisor_tready,
  output logic                u_dividend_tvalid,
  output logic                u_divisor_tvalid,
  input  logic                u_dividend_tready,
  input  logic                u_divisor_tready,
  output logic [DATA_W-1:0]   dividend_tdata,
  output logic [DATA_W-1:0]   divisor_tdata,
  input  logic                s_dout_tvalid,
  input  logic                u_dout_tvalid,
  input  logic [2*DATA_W-1:0] s_dout_tdata,
  input  logic [2*DATA_W-1:0] u_dout_tdata,
  output logic                ready_go,
  output logic                hilo_we,
  output logic [DATA_W-1:0]   lo_wdata,
  output logic [DATA_W-1:0]   hi_wdata,
  output logic                busy
);

  divc_state_t       state_q, state_d;
  logic              sel_signed_q, sel_signed_d;
  logic              abort_q, abort_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;

  logic              is_div, start;
  logic              a_tvalid, b_tvalid, a_tready, b_tready, a_done, b_done;
  logic              dout_v, result_ok;
  logic [2*DATA_W-1:0] dout_data;

  assign is_div = op_div | op_divu;
  assign start  = es_valid & is_div & ~flush;

  assign a_tready  = sel_signed_q ? s_dividend_tready : u_dividend_tready;
  assign b_tready  = sel_signed_q ? s_divisor_tready  : u_divisor_tready;
  assign dout_v    = sel_signed_q ? s_dout_tvalid     : u_dout_tvalid;
  assign dout_data = sel_signed_q ? s_dout_tdata      : u_dout_tdata;

  axis_opnd_chan u_dividend_chan (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q == DIVC_IDLE),
    .en_i     (state_q == DIVC_SEND),
    .tready_i (a_tready),
    .tvalid_o (a_tvalid),
    .done_o   (a_done)
  );

  axis_opnd_chan u_divisor_chan (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q == DIVC_IDLE),
    .en_i     (state_q == DIVC_SEND),
    .tready_i (b_tready),
    .tvalid_o (b_tvalid),
    .done_o   (b_done)
  );

  assign s_dividend_tvalid = a_tvalid &  sel_signed_q;
  assign s_divisor_tvalid  = b_tvalid &  sel_signed_q;
  assign u_dividend_tvalid = a_tvalid & ~sel_signed_q;
  assign u_divisor_tvalid  = b_tvalid & ~sel_signed_q;
  assign dividend_tdata    = a_q;
  assign divisor_tdata     = b_q;

  // A flush arriving with the result wins: the result is dropped.
  assign result_ok = (state_q == DIVC_WAIT) & dout_v & ~abort_q & ~flush;
  assign hilo_we   = result_ok;
  assign lo_wdata  = result_ok ? dout_data[2*DATA_W-1:DATA_W] : '0;
  assign hi_wdata  = result_ok ? dout_data[DATA_W-1:0]        : '0;

  assign ready_go = ((state_q == DIVC_IDLE) & ~is_div) | result_ok | (state_q == DIVC_DONE);
  assign busy     = (state_q != DIVC_IDLE);

  // NOTE: every signal assigned here gets its default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    sel_signed_d = sel_signed_q;
    abort_d      = abort_q;
    a_d          = a_q;
    b_d          = b_q;
    case (state_q)
      DIVC_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          state_d      = DIVC_SEND;
          a_d          = src_a;
          b_d          = src_b;
          sel_signed_d = op_div;
        end
      end
      DIVC_SEND: begin
        if (flush) abort_d = 1'b1;
        if (a_done & b_done) state_d = DIVC_WAIT;
      end
      DIVC_WAIT: begin
        if (flush) abort_d = 1'b1;
        if (dout_v) begin
          abort_d = 1'b0;
          if (abort_q | flush | ms_allowin) state_d = DIVC_IDLE;
          else                              state_d = DIVC_DONE;
        end
      end
      DIVC_DONE: begin
        if (ms_allowin | flush) state_d = DIVC_IDLE;
      end
      default: state_d = DIVC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= DIVC_IDLE;
      sel_signed_q <= 1'b0;
      abort_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      state_q      <= state_d;
      sel_signed_q <= sel_signed_d;
      abort_q      <= abort_d;
      a_q          <= a_d;
      b_q          <= b_d;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: the bench plays EXE, MEM and both divider
// IPs, and checks each operation against arithmetic and latency expectations.
module tb_div_ctrl;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           es_valid, op_div, op_divu, flush, ms_allowin;
  logic [W-1:0]   src_a, src_b;
  logic           s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid;
  logic           s_dividend_tready, s_divisor_tready, u_dividend_tready, u_divisor_tready;
  logic [W-1:0]   dividend_tdata, divisor_tdata;
  logic           s_dout_tvalid, u_dout_tvalid;
  logic [2*W-1:0] s_dout_tdata, u_dout_tdata;
  logic           ready_go, hilo_we, busy;
  logic [W-1:0]   lo_wdata, hi_wdata;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] last_lo, last_hi;
  int last_we_cyc;

  typedef struct {
    bit         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int         lat;
    int         da;
    int         db;
    int         stall;
    int         flush_cyc;
  } op_t;

  div_ctrl #(.DATA_W(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .es_valid          (es_valid),
    .op_div            (op_div),
    .op_divu           (op_divu),
    .flush             (flush),
    .ms_allowin        (ms_allowin),
    .src_a             (src_a),
    .src_b             (src_b),
    .s_dividend_tvalid (s_dividend_tvalid),
    .s_divisor_tvalid  (s_divisor_tvalid),
    .s_dividend_tready (s_dividend_tready),
    .s_divisor_tready  (s_divisor_tready),
    .u_dividend_tvalid (u_dividend_tvalid),
    .u_divisor_tvalid  (u_divisor_tvalid),
    .u_dividend_tready (u_dividend_tready),
    .u_divisor_tready  (u_divisor_tready),
    .dividend_tdata    (dividend_tdata),
    .divisor_tdata     (divisor_tdata),
    .s_dout_tvalid     (s_dout_tvalid),
    .u_dout_tvalid     (u_dout_tvalid),
    .s_dout_tdata      (s_dout_tdata),
    .u_dout_tdata      (u_dout_tdata),
    .ready_go          (ready_go),
    .hilo_we           (hilo_we),
    .lo_wdata          (lo_wdata),
    .hi_wdata          (hi_wdata),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Divider IP behaviour: {quotient, remainder}; divide-by-zero yields a fixed pattern.
  function automatic logic [63:0] ip_result(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    logic [W-1:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (b == '0) return {32'hFFFF_FFFF, a};
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (sb == -1) begin
      q = 32'(-sa);
      r = '0;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
    return {q, r};
  endfunction

  function automatic op_t mk_op(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                input int lat, input int da, input int db, input int stall,
                                input int fl);
    op_t o;
    o.sgn = sgn; o.a = a; o.b = b; o.lat = lat; o.da = da; o.db = db;
    o.stall = stall; o.flush_cyc = fl;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.sgn = 1'($urandom % 2);
    o.a   = $urandom;
    case ($urandom % 8)
      0:       o.b = '0;
      1:       o.b = 32'hFFFF_FFFF;
      2:       o.b = $urandom % 16;
      default: o.b = $urandom;
    endcase
    o.lat   = $urandom_range(0, 6);
    o.da    = $urandom_range(0, 3);
    o.db    = $urandom_range(0, 3);
    o.stall = $urandom_range(0, 3);
    if ($urandom % 4 == 0) o.flush_cyc = $urandom_range(1, 2 + max2(o.da, o.db) + o.lat);
    else                   o.flush_cyc = -1;
    return o;
  endfunction

  // Plays one div/divu from EXE issue to retirement (or to the drained
  // result after a flush); nxt is the instruction that follows a flush.
  task automatic run_op(input op_t op, input bit nxt_valid, input op_t nxt);
    int cyc = 0;
    int dout_cyc = -1;
    int acc_a = -1, acc_b = -1;
    int va_cnt = 0, vb_cnt = 0, wrong = 0, we_cnt = 0;
    logic [W-1:0] got_a = '0, got_b = '0;
    logic [63:0] res;
    bit exp_write, done, killed, ra, rb, dv, sa_v, sb_v, oth;
    logic [63:0] dd;
    res = ip_result(op.sgn, op.a, op.b);
    exp_write = (op.flush_cyc < 0);
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      killed = (op.flush_cyc >= 0) && (cyc > op.flush_cyc);
      flush  = (cyc == op.flush_cyc);
      if (killed) begin
        es_valid = nxt_valid;
        op_div   = nxt_valid & nxt.sgn;
        op_divu  = nxt_valid & ~nxt.sgn;
        src_a    = nxt.a;
        src_b    = nxt.b;
      end else begin
        es_valid = 1'b1;
        op_div   = op.sgn;
        op_divu  = ~op.sgn;
        src_a    = (cyc == 0) ? op.a : $urandom;
        src_b    = (cyc == 0) ? op.b : $urandom;
      end
      ra = (cyc >= 1 + op.da);
      rb = (cyc >= 1 + op.db);
      dv = (cyc == dout_cyc) || (exp_write && dout_cyc >= 0 && cyc > dout_cyc && ($urandom % 2 == 1));
      dd = (cyc == dout_cyc) ? res : {$urandom, $urandom};
      if (op.sgn) begin
        s_dividend_tready = ra; s_divisor_tready = rb;
        u_dividend_tready = 1'b1; u_divisor_tready = 1'b1;
        s_dout_tvalid = dv; s_dout_tdata = dd;
        u_dout_tvalid = 1'($urandom % 2); u_dout_tdata = {$urandom, $urandom};
      end else begin
        u_dividend_tready = ra; u_divisor_tready = rb;
        s_dividend_tready = 1'b1; s_divisor_tready = 1'b1;
        u_dout_tvalid = dv; u_dout_tdata = dd;
        s_dout_tvalid = 1'($urandom % 2); s_dout_tdata = {$urandom, $urandom};
      end
      ms_allowin = !(dout_cyc >= 0 && cyc >= dout_cyc && cyc < dout_cyc + op.stall);
      #1;
      sa_v = op.sgn ? s_dividend_tvalid : u_dividend_tvalid;
      sb_v = op.sgn ? s_divisor_tvalid  : u_divisor_tvalid;
      oth  = op.sgn ? (u_dividend_tvalid | u_divisor_tvalid) : (s_dividend_tvalid | s_divisor_tvalid);
      if (sa_v) va_cnt++;
      if (sb_v) vb_cnt++;
      if (oth)  wrong++;
      if (sa_v && ra && acc_a < 0) begin acc_a = cyc; got_a = dividend_tdata; end
      if (sb_v && rb && acc_b < 0) begin acc_b = cyc; got_b = divisor_tdata; end
      check("ready_go", 64'(ready_go),
            64'(exp_write && dout_cyc >= 0 && cyc >= dout_cyc && cyc <= dout_cyc + op.stall));
      check("hilo_we", 64'(hilo_we), 64'(exp_write && cyc == dout_cyc));
      check("busy", 64'(busy), 64'(cyc >= 1));
      if (hilo_we) begin
        we_cnt++;
        last_lo = lo_wdata;
        last_hi = hi_wdata;
        last_we_cyc = cyc;
      end
      if (dout_cyc < 0 && acc_a >= 0 && acc_b >= 0) dout_cyc = max2(acc_a, acc_b) + 1 + op.lat;
      if (dout_cyc >= 0) done = exp_write ? (cyc == dout_cyc + op.stall) : (cyc == dout_cyc);
      cyc++;
    end
    check("op_done", 64'(done), 64'(1));
    check("we_count", 64'(we_cnt), 64'(exp_write));
    check("dividend_valid_cycles", 64'(va_cnt), 64'(op.da + 1));
    check("divisor_valid_cycles", 64'(vb_cnt), 64'(op.db + 1));
    check("other_ip_valids", 64'(wrong), 64'(0));
    check("ip_dividend", 64'(got_a), 64'(op.a));
    check("ip_divisor", 64'(got_b), 64'(op.b));
    if (exp_write) begin
      check("lo_quotient", 64'(last_lo), 64'(res[63:32]));
      check("hi_remainder", 64'(last_hi), 64'(res[31:0]));
      check("latency", 64'(last_we_cyc), 64'(2 + max2(op.da, op.db) + op.lat));
    end
  endtask

  initial begin
    op_t o1, o2, cur, nxt;
    reset = 1'b1;
    es_valid = 1'b0; op_div = 1'b0; op_divu = 1'b0; flush = 1'b0; ms_allowin = 1'b1;
    src_a = '0; src_b = '0;
    s_dividend_tready = 1'b0; s_divisor_tready = 1'b0;
    u_dividend_tready = 1'b0; u_divisor_tready = 1'b0;
    s_dout_tvalid = 1'b0; u_dout_tvalid = 1'b0; s_dout_tdata = '0; u_dout_tdata = '0;
    last_lo = '0; last_hi = '0; last_we_cyc = -1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valids", 64'({s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready_go", 64'(ready_go), 64'(1));
    check("rst_hilo_we", 64'(hilo_we), 64'(0));
    check("rst_tdata", {dividend_tdata, divisor_tdata}, 64'(0));
    check("rst_wdata", {hi_wdata, lo_wdata}, 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Signed -7/2, IP latency 8, ready immediately.
    o1 = mk_op(1'b1, 32'hFFFF_FFF9, 32'd2, 8, 0, 0, 0, -1);
    run_op(o1, 1'b0, o1);
    check("div_lo", 64'(last_lo), 64'h0000_0000_FFFF_FFFD);
    check("div_hi", 64'(last_hi), 64'h0000_0000_FFFF_FFFF);
    check("div_we_cycle", 64'(last_we_cyc), 64'(10));

    // Unsigned 0xFFFFFFFF/0x10.
    o1 = mk_op(1'b0, 32'hFFFF_FFFF, 32'h10, 3, 0, 0, 0, -1);
    run_op(o1, 1'b0, o1);
    check("divu_lo", 64'(last_lo), 64'h0000_0000_0FFF_FFFF);
    check("divu_hi", 64'(last_hi), 64'h0000_0000_0000_000F);

    // Staggered handshake, then MEM backpressure for 5 cycles.
    o1 = mk_op(1'b1, 32'd1234, 32'd10, 4, 3, 0, 0, -1);
    run_op(o1, 1'b0, o1);
    o1 = mk_op(1'b0, 32'd99, 32'd4, 2, 0, 1, 5, -1);
    run_op(o1, 1'b0, o1);

    // Flush in WAIT with the next divu queued behind the drain.
    o1 = mk_op(1'b1, 32'd100, 32'd7, 6, 0, 0, 0, 4);
    o2 = mk_op(1'b0, 32'd1000, 32'd7, 2, 1, 0, 1, -1);
    run_op(o1, 1'b1, o2);
    run_op(o2, 1'b0, o2);
    check("post_flush_lo", 64'(last_lo), 64'(142));
    check("post_flush_hi", 64'(last_hi), 64'(6));

    // Divide by zero passes the IP result through.
    o1 = mk_op(1'b0, 32'hDEAD_BEEF, 32'd0, 1, 0, 2, 0, -1);
    run_op(o1, 1'b0, o1);

    // Reset while in SEND.
    @(negedge clk);
    es_valid = 1'b1; op_div = 1'b1; op_divu = 1'b0; flush = 1'b0; ms_allowin = 1'b1;
    src_a = 32'd55; src_b = 32'd5;
    s_dividend_tready = 1'b0; s_divisor_tready = 1'b0;
    s_dout_tvalid = 1'b0; u_dout_tvalid = 1'b0;
    @(negedge clk);
    #1;
    check("rs_send_valid", 64'(s_dividend_tvalid), 64'(1));
    reset = 1'b1; es_valid = 1'b0; op_div = 1'b0;
    @(negedge clk);
    #1;
    check("rs_valids", 64'({s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid}), 64'(0));
    check("rs_busy", 64'(busy), 64'(0));
    check("rs_ready_go", 64'(ready_go), 64'(1));
    repeat (8) @(negedge clk);
    reset = 1'b0;

    // Randomized operations, some flushed with a follower queued.
    cur = rand_op();
    for (int i = 0; i < 40; i++) begin
      nxt = rand_op();
      run_op(cur, (i < 39), nxt);
      cur = nxt;
    end
    @(negedge clk);
    es_valid = 1'b0; op_div = 1'b0; op_divu = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
